control_sequencer: RTL and testbench

//  Multi-cycle control unit for the 32-bit bus datapath. Steps fetch (T0-T2) and execute (T3-T7)
//  per IR opcode and drives every register in/out strobe, ALU op select and memory handshake.

---
 rtl/cpu_ctrl_pkg.sv | 67 ++++++
 rtl/reg_select_decoder.sv | 11 +
 rtl/control_sequencer.sv | 165 ++++++++++++++++
 tb/tb_control_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types and constants for the control sequencer.
//   state_t     - FSM states (S_MRD is the fetch memory-read sub-state of T1)
//   op_class_t  - instruction families that share an execute sequence
//   OP_*        - 5-bit opcodes taken from ir[31:27]
//   ALU_*       - one-hot alu_op patterns; bit index = position in
//                 {NOT,NEG,ROL,ROR,SHL,SHRA,SHR,OR,AND,DIV,MUL,SUB,ADD}
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_MRD, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_RTYPE, C_ITYPE, C_UNARY, C_MULDIV, C_LD, C_ST
  } op_class_t;

  localparam logic [4:0] OP_LD   = 5'h00, OP_ST   = 5'h02, OP_ADD  = 5'h03,
                         OP_SUB  = 5'h04, OP_AND  = 5'h05, OP_OR   = 5'h06,
                         OP_SHR  = 5'h07, OP_SHRA = 5'h08, OP_SHL  = 5'h09,
                         OP_ROR  = 5'h0A, OP_ROL  = 5'h0B, OP_ADDI = 5'h0C,
                         OP_ANDI = 5'h0D, OP_ORI  = 5'h0E, OP_DIV  = 5'h0F,
                         OP_MUL  = 5'h10, OP_NEG  = 5'h11, OP_NOT  = 5'h12,
                         OP_NOP  = 5'h1A, OP_HALT = 5'h1B;

  localparam logic [12:0] ALU_ADD  = 13'h0001, ALU_SUB = 13'h0002, ALU_MUL = 13'h0004,
                          ALU_DIV  = 13'h0008, ALU_AND = 13'h0010, ALU_OR  = 13'h0020,
                          ALU_SHR  = 13'h0040, ALU_SHRA = 13'h0080, ALU_SHL = 13'h0100,
                          ALU_ROR  = 13'h0200, ALU_ROL = 13'h0400, ALU_NEG = 13'h0800,
                          ALU_NOT  = 13'h1000;

  // NOP, HALT and every undefined opcode fall into C_NONE.
  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      OP_LD:                                   op_class = C_LD;
      OP_ST:                                   op_class = C_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:         op_class = C_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:                op_class = C_ITYPE;
      OP_DIV, OP_MUL:                          op_class = C_MULDIV;
      OP_NEG, OP_NOT:                          op_class = C_UNARY;
      default:                                 op_class = C_NONE;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [4:0] op);
    is_illegal = (op_class(op) == C_NONE) && (op != OP_NOP) && (op != OP_HALT);
  endfunction

  function automatic logic [12:0] alu_sel(input logic [4:0] op);
    case (op)
      OP_SUB:               alu_sel = ALU_SUB;
      OP_MUL:               alu_sel = ALU_MUL;
      OP_DIV:               alu_sel = ALU_DIV;
      OP_AND, OP_ANDI:      alu_sel = ALU_AND;
      OP_OR, OP_ORI:        alu_sel = ALU_OR;
      OP_SHR:               alu_sel = ALU_SHR;
      OP_SHRA:              alu_sel = ALU_SHRA;
      OP_SHL:               alu_sel = ALU_SHL;
      OP_ROR:               alu_sel = ALU_ROR;
      OP_ROL:               alu_sel = ALU_ROL;
      OP_NEG:               alu_sel = ALU_NEG;
      OP_NOT:               alu_sel = ALU_NOT;
      default:              alu_sel = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// reg_select_decoder: 4-bit register field -> 16-bit one-hot strobe.
//   sel    in  4   register number
//   en     in  1   strobe enable; output is all-zero when low
//   onehot out 16  R0..R15 strobe
module reg_select_decoder (
  input  logic [3:0]  sel,
  input  logic        en,
  output logic [15:0] onehot
);
  assign onehot = en ? (16'd1 << sel) : 16'd0;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle control unit for the 32-bit bus datapath.
// Fetch T0..T2 (with a memory-read sub-state after T1), execute T3..T7 per
// latched opcode. All strobes are decoded from state + latched op; mdr_in in
// a read state follows mem_ready so the MDR loads only on the completing cycle.
// Ports: clock, clear (async active-low), start, ir[31:0], mem_ready;
//   reg_in/reg_out[15:0] one-hot, datapath strobes, alu_op[12:0] one-hot,
//   mem_read/mem_write, running, halted, illegal_op, mem_fault.
// Build option: SINGLE_STEP_EN adds input step; each instruction then ends
//   in IDLE and waits for step (or start) instead of running back-to-back.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [15:0] reg_in,
  output logic [15:0] reg_out,
  output logic        pc_in, pc_out, inc_pc, mar_in, mdr_in, mdr_out,
  output logic        md_mux_read, ir_in, y_in, cse_out,
  output logic        zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in,
  output logic [12:0] alu_op,
  output logic        mem_read, mem_write,
  output logic        running, halted, illegal_op, mem_fault
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t    state_q, state_d, s_done;
  op_class_t cls;
  logic [4:0] op_q;
  logic [3:0] ra_q, rb_q, rc_q, in_sel, out_sel;
  logic [7:0] wait_cnt;
  logic       go, mem_state, timeout, in_en, out_en, illegal_q, fault_q;
  logic       unused_ir;

  assign unused_ir = ^ir[14:0];   // immediate field belongs to the datapath
  assign cls       = op_class(op_q);

`ifdef SINGLE_STEP_EN
  assign go     = start | step;
  assign s_done = S_IDLE;
`else
  assign go     = start;
  assign s_done = S_T0;
`endif

  assign mem_state = (state_q == S_MRD) ||
                     (state_q == S_T6 && cls == C_LD) ||
                     (state_q == S_T7 && cls == C_ST);
  // mem_ready on the last allowed cycle still completes, so it masks timeout.
  assign timeout   = mem_state && !mem_ready && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      if (state_q == S_T2) {op_q, ra_q, rb_q, rc_q} <= ir[31:15];
      wait_cnt  <= mem_state ? wait_cnt + 8'd1 : 8'd0;
      illegal_q <= (state_q == S_T2) && is_illegal(ir[31:27]);
      if (timeout) fault_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (go) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_MRD;
      S_MRD:  if (mem_ready) state_d = S_T2;
              else if (timeout) state_d = S_HALT;
      S_T2:   if (ir[31:27] == OP_HALT) state_d = S_HALT;
              else if (op_class(ir[31:27]) == C_NONE) state_d = s_done;
              else state_d = S_T3;
      S_T3:   state_d = S_T4;
      S_T4:   state_d = (cls == C_UNARY) ? s_done : S_T5;
      S_T5:   state_d = (cls == C_RTYPE || cls == C_ITYPE) ? s_done : S_T6;
      S_T6:   case (cls)
                C_LD:    if (mem_ready) state_d = S_T7;
                         else if (timeout) state_d = S_HALT;
                C_ST:    state_d = S_T7;
                default: state_d = s_done;
              endcase
      S_T7:   if (cls != C_ST || mem_ready) state_d = s_done;
              else if (timeout) state_d = S_HALT;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_in = 1'b0; pc_out = 1'b0; inc_pc = 1'b0; mar_in = 1'b0;
    mdr_in = 1'b0; mdr_out = 1'b0; md_mux_read = 1'b0; ir_in = 1'b0;
    y_in = 1'b0; cse_out = 1'b0; zhigh_in = 1'b0; zlow_in = 1'b0;
    zhigh_out = 1'b0; zlow_out = 1'b0; hi_in = 1'b0; lo_in = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; halted = 1'b0;
    alu_op = '0;
    in_en = 1'b0; in_sel = ra_q; out_en = 1'b0; out_sel = rb_q;
    case (state_q)
      S_T0:  begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; zlow_in = 1'b1; end
      S_T1:  begin zlow_out = 1'b1; pc_in = 1'b1; end
      S_MRD: begin mem_read = 1'b1; md_mux_read = 1'b1; mdr_in = mem_ready; end
      S_T2:  begin mdr_out = 1'b1; ir_in = 1'b1; end
      S_T3:  case (cls)
               C_UNARY:  begin out_en = 1'b1; alu_op = alu_sel(op_q); zlow_in = 1'b1; end
               C_MULDIV: begin out_en = 1'b1; out_sel = ra_q; y_in = 1'b1; end
               C_NONE:   ;
               default:  begin out_en = 1'b1; y_in = 1'b1; end
             endcase
      S_T4:  case (cls)
               C_RTYPE:  begin out_en = 1'b1; out_sel = rc_q; alu_op = alu_sel(op_q); zlow_in = 1'b1; end
               C_ITYPE:  begin cse_out = 1'b1; alu_op = alu_sel(op_q); zlow_in = 1'b1; end
               C_LD, C_ST: begin cse_out = 1'b1; alu_op = ALU_ADD; zlow_in = 1'b1; end
               C_UNARY:  begin zlow_out = 1'b1; in_en = 1'b1; end
               C_MULDIV: begin out_en = 1'b1; alu_op = alu_sel(op_q); zhigh_in = 1'b1; zlow_in = 1'b1; end
               default:  ;
             endcase
      S_T5:  case (cls)
               C_RTYPE, C_ITYPE: begin zlow_out = 1'b1; in_en = 1'b1; end
               C_MULDIV:         begin zlow_out = 1'b1; lo_in = 1'b1; end
               C_LD, C_ST:       begin zlow_out = 1'b1; mar_in = 1'b1; end
               default:          ;
             endcase
      S_T6:  case (cls)
               C_MULDIV: begin zhigh_out = 1'b1; hi_in = 1'b1; end
               C_LD:     begin mem_read = 1'b1; md_mux_read = 1'b1; mdr_in = mem_ready; end
               C_ST:     begin out_en = 1'b1; out_sel = ra_q; mdr_in = 1'b1; end
               default:  ;
             endcase
      S_T7:  case (cls)
               C_LD:    begin mdr_out = 1'b1; in_en = 1'b1; end
               C_ST:    mem_write = 1'b1;
               default: ;
             endcase
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign running    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign illegal_op = illegal_q;
  assign mem_fault  = fault_q;

  reg_select_decoder u_in_dec  (.sel(in_sel),  .en(in_en),  .onehot(reg_in));
  reg_select_decoder u_out_dec (.sel(out_sel), .en(out_en), .onehot(reg_out));

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: reset, fetch, R-type, unary, MUL,
// LD with wait states, ST timeout, wait-limit boundary, NOP, illegal, HALT.
module tb_control_sequencer;

  logic        clock, clear, start, mem_ready;
  logic [31:0] ir;
  logic [15:0] reg_in, reg_out;
  logic        pc_in, pc_out, inc_pc, mar_in, mdr_in, mdr_out, md_mux_read, ir_in, y_in, cse_out;
  logic        zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in;
  logic [12:0] alu_op;
  logic        mem_read, mem_write, running, halted, illegal_op, mem_fault;

  int passed = 0;
  int total  = 0;

  localparam logic [17:0] P_PCIN = 18'h20000, P_PCOUT = 18'h10000, P_INC = 18'h08000,
                          P_MARIN = 18'h04000, P_MDRIN = 18'h02000, P_MDROUT = 18'h01000,
                          P_MDMUX = 18'h00800, P_IRIN = 18'h00400, P_YIN = 18'h00200,
                          P_CSE = 18'h00100, P_ZHIN = 18'h00080, P_ZLIN = 18'h00040,
                          P_ZHOUT = 18'h00020, P_ZLOUT = 18'h00010, P_HIIN = 18'h00008,
                          P_LOIN = 18'h00004, P_MRD = 18'h00002, P_MWR = 18'h00001;
  localparam logic [17:0] T0_CTL = P_PCOUT | P_MARIN | P_INC | P_ZLIN;

  control_sequencer #(.MEM_WAIT_MAX(15)) dut (
    .clock(clock), .clear(clear), .start(start), .ir(ir), .mem_ready(mem_ready),
    .reg_in(reg_in), .reg_out(reg_out),
    .pc_in(pc_in), .pc_out(pc_out), .inc_pc(inc_pc), .mar_in(mar_in), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .md_mux_read(md_mux_read), .ir_in(ir_in), .y_in(y_in), .cse_out(cse_out),
    .zhigh_in(zhigh_in), .zlow_in(zlow_in), .zhigh_out(zhigh_out), .zlow_out(zlow_out),
    .hi_in(hi_in), .lo_in(lo_in), .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
    .running(running), .halted(halted), .illegal_op(illegal_op), .mem_fault(mem_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [17:0] ctl();
    return {pc_in, pc_out, inc_pc, mar_in, mdr_in, mdr_out, md_mux_read, ir_in, y_in, cse_out,
            zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in, mem_read, mem_write};
  endfunction

  // {ctl, reg_in, reg_out, alu_op}
  function automatic logic [62:0] snap();
    return {ctl(), reg_in, reg_out, alu_op};
  endfunction

  function automatic logic [66:0] everything();
    return {snap(), running, halted, illegal_op, mem_fault};
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'h0};
  endfunction

  // Leaves the FSM in IDLE, positioned just after a falling edge.
  task automatic do_reset();
    clear = 1'b0; start = 1'b0; mem_ready = 1'b0;
    @(negedge clock); clear = 1'b1; #1;
  endtask

  // Runs T0, T1, one MEMRD cycle (ready at once) and stops sampled in T2.
  task automatic run_fetch();
    start = 1'b1;
    @(negedge clock); start = 1'b0; #1;
    @(negedge clock); #1;
    @(negedge clock); mem_ready = 1'b1; #1;
    @(negedge clock); mem_ready = 1'b0; #1;
  endtask

  task automatic test_reset();
    clear = 1'b0; start = 1'b0; mem_ready = 1'b0; ir = '0;
    #2;
    total++; if (everything() !== 67'h0) $display("FAIL reset_outputs got %h want 0", everything()); else passed++;
  endtask

  task automatic test_add();
    do_reset();
    ir = mk(5'h03, 4'd5, 4'd2, 4'd4);
    start = 1'b1;
    @(negedge clock); start = 1'b0; #1;
    total++; if ({snap(), running} !== {T0_CTL, 45'h0, 1'b1}) $display("FAIL add_t0 got %h want %h", {snap(), running}, {T0_CTL, 45'h0, 1'b1}); else passed++;
    @(negedge clock); #1;
    total++; if (snap() !== {P_ZLOUT | P_PCIN, 45'h0}) $display("FAIL add_t1 got %h want %h", snap(), {P_ZLOUT | P_PCIN, 45'h0}); else passed++;
    @(negedge clock); mem_ready = 1'b1; #1;
    total++; if (snap() !== {P_MRD | P_MDMUX | P_MDRIN, 45'h0}) $display("FAIL add_memrd got %h want %h", snap(), {P_MRD | P_MDMUX | P_MDRIN, 45'h0}); else passed++;
    @(negedge clock); mem_ready = 1'b0; #1;
    total++; if (snap() !== {P_MDROUT | P_IRIN, 45'h0}) $display("FAIL add_t2 got %h want %h", snap(), {P_MDROUT | P_IRIN, 45'h0}); else passed++;
    @(negedge clock); #1;
    total++; if (snap() !== {P_YIN, 16'h0, 16'h0004, 13'h0}) $display("FAIL add_t3 got %h want %h", snap(), {P_YIN, 16'h0, 16'h0004, 13'h0}); else passed++;
    @(negedge clock); #1;
    total++; if (snap() !== {P_ZLIN, 16'h0, 16'h0010, 13'h0001}) $display("FAIL add_t4 got %h want %h", snap(), {P_ZLIN, 16'h0, 16'h0010, 13'h0001}); else passed++;
    @(negedge clock); #1;
    total++; if (snap() !== {P_ZLOUT, 16'h0020, 16'h0, 13'h0}) $display("FAIL add_t5 got %h want %h", snap(), {P_ZLOUT, 16'h0020, 16'h0, 13'h0}); else passed++;
    @(negedge clock); #1;
    total++; if (snap() !== {T0_CTL, 45'h0}) $display("FAIL add_back_t0 got %h want %h", snap(), {T0_CTL, 45'h0}); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ir = mk(5'h03, 4'd5, 4'd2, 4'd4);
    run_fetch();
    @(negedge clock); #1;
    @(negedge clock); #1;
    total++; if (alu_op !== 13'h0001) $display("FAIL midrst_in_t4 got %h want 0001", alu_op); else passed++;
    #2 clear = 1'b0; #1;
    total++; if (everything() !== 67'h0) $display("FAIL midrst_outputs got %h want 0", everything()); else passed++;
    @(negedge clock); clear = 1'b1; start = 1'b1;
    @(negedge clock); start = 1'b0; #1;
    total++; if ({snap(), running} !== {T0_CTL, 45'h0, 1'b1}) $display("FAIL midrst_restart got %h want %h", {snap(), running}, {T0_CTL, 45'h0, 1'b1}); else passed++;
  endtask

  task automatic test_not();
    do_reset();
    ir = mk(5'h12, 4'd7, 4'd9, 4'd0);
    run_fetch();
    @(negedge clock); #1;
    total++; if (snap() !== {P_ZLIN, 16'h0, 16'h0200, 13'h1000}) $display("FAIL not_t3 got %h want %h", snap(), {P_ZLIN, 16'h0, 16'h0200, 13'h1000}); else passed++;
    @(negedge clock); #1;
    total++; if (snap() !== {P_ZLOUT, 16'h0080, 16'h0, 13'h0}) $display("FAIL not_t4 got %h want %h", snap(), {P_ZLOUT, 16'h0080, 16'h0, 13'h0}); else passed++;
    @(negedge clock); #1;
    total++; if (ctl() !== T0_CTL) $display("FAIL not_next_t0 got %h want %h", ctl(), T0_CTL); else passed++;
  endtask

  task automatic test_mul();
    logic [15:0] any_in;
    do_reset();
    ir = mk(5'h10, 4'd3, 4'd1, 4'd0);
    run_fetch();
    any_in = reg_in;
    @(negedge clock); #1; any_in |= reg_in;
    total++; if (snap() !== {P_YIN, 16'h0, 16'h0008, 13'h0}) $display("FAIL mul_t3 got %h want %h", snap(), {P_YIN, 16'h0, 16'h0008, 13'h0}); else passed++;
    @(negedge clock); #1; any_in |= reg_in;
    total++; if (snap() !== {P_ZHIN | P_ZLIN, 16'h0, 16'h0002, 13'h0004}) $display("FAIL mul_t4 got %h want %h", snap(), {P_ZHIN | P_ZLIN, 16'h0, 16'h0002, 13'h0004}); else passed++;
    @(negedge clock); #1; any_in |= reg_in;
    total++; if (snap() !== {P_ZLOUT | P_LOIN, 45'h0}) $display("FAIL mul_t5 got %h want %h", snap(), {P_ZLOUT | P_LOIN, 45'h0}); else passed++;
    @(negedge clock); #1; any_in |= reg_in;
    total++; if (snap() !== {P_ZHOUT | P_HIIN, 45'h0}) $display("FAIL mul_t6 got %h want %h", snap(), {P_ZHOUT | P_HIIN, 45'h0}); else passed++;
    total++; if (any_in !== 16'h0) $display("FAIL mul_no_reg_in got %h want 0000", any_in); else passed++;
    @(negedge clock); #1;
    total++; if (ctl() !== T0_CTL) $display("FAIL mul_next_t0 got %h want %h", ctl(), T0_CTL); else passed++;
  endtask

  task automatic test_ld_wait();
    int nrd = 0;
    int bad = 0;
    do_reset();
    ir = mk(5'h00, 4'd1, 4'd2, 4'd0) | 32'h10;
    run_fetch();
    @(negedge clock); #1;
    total++; if (snap() !== {P_YIN, 16'h0, 16'h0004, 13'h0}) $display("FAIL ld_t3 got %h want %h", snap(), {P_YIN, 16'h0, 16'h0004, 13'h0}); else passed++;
    @(negedge clock); #1;
    total++; if (snap() !== {P_CSE | P_ZLIN, 32'h0, 13'h0001}) $display("FAIL ld_t4 got %h want %h", snap(), {P_CSE | P_ZLIN, 32'h0, 13'h0001}); else passed++;
    @(negedge clock); #1;
    total++; if (snap() !== {P_ZLOUT | P_MARIN, 45'h0}) $display("FAIL ld_t5 got %h want %h", snap(), {P_ZLOUT | P_MARIN, 45'h0}); else passed++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock); mem_ready = (k == 3); #1;
      if (mem_read) nrd++;
      if (mdr_in !== (k == 3)) bad++;
    end
    @(negedge clock); mem_ready = 1'b0; #1;
    total++; if (nrd != 4) $display("FAIL ld_mem_read_cycles got %0d want 4", nrd); else passed++;
    total++; if (bad != 0) $display("FAIL ld_mdr_in_timing got %0d wrong cycles want 0", bad); else passed++;
    total++; if (snap() !== {P_MDROUT, 16'h0002, 16'h0, 13'h0}) $display("FAIL ld_t7 got %h want %h", snap(), {P_MDROUT, 16'h0002, 16'h0, 13'h0}); else passed++;
  endtask

  task automatic test_st_timeout();
    int nwr = 0;
    do_reset();
    ir = mk(5'h02, 4'd1, 4'd2, 4'd0);
    run_fetch();
    repeat (3) begin @(negedge clock); #1; end
    @(negedge clock); #1;
    total++; if (snap() !== {P_MDRIN, 16'h0, 16'h0002, 13'h0}) $display("FAIL st_t6 got %h want %h", snap(), {P_MDRIN, 16'h0, 16'h0002, 13'h0}); else passed++;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock); #1;
      if (mem_write) nwr++;
      else break;
    end
    total++; if (nwr != 15) $display("FAIL st_write_cycles got %0d want 15", nwr); else passed++;
    total++; if ({halted, running, mem_fault, mem_write} !== 4'b1010) $display("FAIL st_fault_halt got %b want 1010", {halted, running, mem_fault, mem_write}); else passed++;
    start = 1'b1;
    repeat (3) begin @(negedge clock); #1; end
    start = 1'b0;
    total++; if ({halted, running, mem_fault, ctl()} !== {3'b101, 18'h0}) $display("FAIL st_fault_sticky got %h want %h", {halted, running, mem_fault, ctl()}, {3'b101, 18'h0}); else passed++;
  endtask

  task automatic test_wait_boundary();
    int early = 0;
    do_reset();
    ir = mk(5'h1A, 4'd0, 4'd0, 4'd0);
    start = 1'b1;
    @(negedge clock); start = 1'b0; #1;
    @(negedge clock); #1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock); mem_ready = (k == 14); #1;
      if (!mem_read) early++;
    end
    @(negedge clock); mem_ready = 1'b0; #1;
    total++; if (early != 0) $display("FAIL edge_memrd_held got %0d gaps want 0", early); else passed++;
    total++; if ({ctl(), halted, mem_fault} !== {P_MDROUT | P_IRIN, 2'b00}) $display("FAIL edge_ready_wins got %h want %h", {ctl(), halted, mem_fault}, {P_MDROUT | P_IRIN, 2'b00}); else passed++;
    @(negedge clock); #1;
    total++; if ({ctl(), illegal_op} !== {T0_CTL, 1'b0}) $display("FAIL nop_to_t0 got %h want %h", {ctl(), illegal_op}, {T0_CTL, 1'b0}); else passed++;
  endtask

  task automatic test_illegal();
    do_reset();
    ir = mk(5'h1F, 4'd0, 4'd0, 4'd0);
    run_fetch();
    @(negedge clock); #1;
    total++; if ({illegal_op, ctl()} !== {1'b1, T0_CTL}) $display("FAIL illegal_pulse got %h want %h", {illegal_op, ctl()}, {1'b1, T0_CTL}); else passed++;
    @(negedge clock); #1;
    total++; if (illegal_op !== 1'b0) $display("FAIL illegal_one_cycle got %b want 0", illegal_op); else passed++;
  endtask

  task automatic test_halt();
    do_reset();
    ir = mk(5'h1B, 4'd0, 4'd0, 4'd0);
    run_fetch();
    @(negedge clock); #1;
    total++; if ({halted, running, ctl()} !== {2'b10, 18'h0}) $display("FAIL halt_enter got %h want %h", {halted, running, ctl()}, {2'b10, 18'h0}); else passed++;
    start = 1'b1;
    repeat (3) begin @(negedge clock); #1; end
    start = 1'b0;
    total++; if ({halted, running, ctl(), mem_fault} !== {2'b10, 18'h0, 1'b0}) $display("FAIL halt_ignores_start got %h want %h", {halted, running, ctl(), mem_fault}, {2'b10, 18'h0, 1'b0}); else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_reset_mid();
    test_not();
    test_mul();
    test_ld_wait();
    test_st_timeout();
    test_wait_boundary();
    test_illegal();
    test_halt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d checks", total);
    $fatal(1, "watchdog");
  end

endmodule
